prog_loader: RTL

Upstream boot stage for the 8-bit RISC core. Receives a framed program image as a byte stream, writes it into the 8K x 8 program memory from address 0, and verifies a modulo-256 checksum. It holds the core in reset until a valid image is loaded. It then hands the program-memory address and read strobe to the core.

---
 rtl/prog_loader.sv | 102 ++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Boot loader: receives a framed program image, writes it into program memory from
// address 0, verifies the mod-256 checksum, then releases the core onto the memory port.
module prog_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic [12:0] cpu_addr,
    input  logic        cpu_rd,
    output logic [12:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_rd,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_RUN, S_ERR
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] len_q;
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] load_addr_q;
    logic [DW-1:0] acc_q;
    logic [AW-1:0] cnt_inc_c;
    logic          accept_c;

    // load_start wins over a byte offered in the same cycle
    assign accept_c  = in_valid && in_ready && !load_start;
    assign cnt_inc_c = cnt_q + AW'(1);

    // Next-state logic
    always_comb begin
        state_n = state;
        if (load_start) begin
            state_n = S_LEN_HI;
        end else if (accept_c) begin
            case (state)
                S_LEN_HI: state_n = (in_data[7:5] != 3'b000) ? S_ERR : S_LEN_LO;
                S_LEN_LO: state_n = ({len_q[12:8], in_data} == AW'(0)) ? S_CSUM : S_DATA;
                S_DATA:   state_n = (cnt_inc_c == len_q) ? S_CSUM : S_DATA;
                S_CSUM:   state_n = (in_data == acc_q) ? S_RUN : S_ERR;
                default:  state_n = state;
            endcase
        end
    end

    // State, datapath and Moore outputs registered from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            in_ready    <= 1'b0;
            cpu_hold    <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            load_addr_q <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
        end else begin
            state    <= state_n;
            in_ready <= (state_n == S_LEN_HI) || (state_n == S_LEN_LO) ||
                        (state_n == S_DATA)   || (state_n == S_CSUM);
            cpu_hold <= (state_n != S_RUN);
            done     <= (state_n == S_RUN);
            err      <= (state_n == S_ERR);
            mem_we   <= 1'b0;
            if (load_start) begin
                cnt_q <= '0;
                acc_q <= '0;
            end else if (accept_c) begin
                case (state)
                    S_LEN_HI: len_q[12:8] <= in_data[4:0];
                    S_LEN_LO: len_q[7:0]  <= in_data;
                    S_DATA: begin
                        mem_we      <= 1'b1;
                        mem_wdata   <= in_data;
                        load_addr_q <= cnt_q;
                        cnt_q       <= cnt_inc_c;
                        acc_q       <= acc_q + in_data;
                    end
                    default: ;
                endcase
            end
        end
    end

    // The core owns the memory port only once the image is verified
    assign mem_addr = (state == S_RUN) ? cpu_addr : load_addr_q;
    assign mem_rd   = (state == S_RUN) && cpu_rd;

endmodule
